// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide sequencer.
package mdu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    CALC = 2'b10,
    FIX  = 2'b11
  } mdu_state_e;

  // LO value reported for a divide by zero
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_seq_ctrl_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*XLEN accumulator.
// Multiply: acc = {partial product, remaining multiplier bits}.
// Divide:   acc = {partial remainder, dividend bits / quotient bits}.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]     sum;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] shl;

  // Compute both iteration flavours and pick by mode
  always_comb begin
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    shl   = acc << 1;
    // The bit shifted out of the remainder is kept as the 33rd trial bit
    trial = {acc[2*XLEN-1], shl[2*XLEN-1:XLEN]} - {1'b0, operand};
    if (is_div) begin
      if (!trial[XLEN]) acc_next = {trial[XLEN-1:0], shl[XLEN-1:1], 1'b1};
      else              acc_next = shl;
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Iterative multiply/divide sequencer owning the architectural HI/LO registers.
//   state | meaning
//   IDLE  | waiting for start; services mthi/mtlo
//   PREP  | initialise accumulator, catch divide by zero
//   CALC  | one shift-add / restoring-divide step per cycle (XLEN steps)
//   FIX   | sign correction, write HI/LO, pulse done
module mdu_seq_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_e        state;
  mdu_op_e           op_q;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              sign_p;
  logic              sign_r;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [CNT_W-1:0]  cnt;

  logic              in_signed;
  logic              rs_neg;
  logic              rt_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   rs_orig;
  logic              div_zero;

  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div   (op_is_div(op_q)),
    .acc      (acc),
    .operand  (op_is_div(op_q) ? mag_b : mag_a),
    .acc_next (acc_next)
  );

  // Operand sign decode and final sign-corrected results
  always_comb begin
    in_signed = op_is_signed(mdu_op_e'(op));
    rs_neg    = in_signed & rs_val[XLEN-1];
    rt_neg    = in_signed & rt_val[XLEN-1];
    prod_fix  = sign_p ? -acc : acc;
    quo_fix   = sign_p ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix   = sign_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    // The dividend is rebuilt from its magnitude so it need not be stored twice
    rs_orig   = sign_r ? -mag_a : mag_a;
    div_zero  = op_is_div(op_q) && (mag_b == '0);
  end

  // Sequencer FSM, iteration counter and HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= MDU_MULT;
      mag_a       <= '0;
      mag_b       <= '0;
      sign_p      <= 1'b0;
      sign_r      <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (flush && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !flush) begin
              op_q   <= mdu_op_e'(op);
              mag_a  <= rs_neg ? -rs_val : rs_val;
              mag_b  <= rt_neg ? -rt_val : rt_val;
              sign_p <= rs_neg ^ rt_neg;
              sign_r <= rs_neg;
              busy   <= 1'b1;
              state  <= PREP;
            end else if (!start) begin
              if (hi_we) hi <= wdata;
              if (lo_we) lo <= wdata;
            end
          end
          PREP: begin
            if (div_zero) begin
              state <= FIX;
            end else begin
              // Multiplier or dividend enters the low half and is consumed bit by bit
              acc   <= {{XLEN{1'b0}}, op_is_div(op_q) ? mag_a : mag_b};
              cnt   <= '0;
              state <= CALC;
            end
          end
          CALC: begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
          end
          FIX: begin
            if (div_zero) begin
              hi <= rs_orig;
              lo <= DIV0_LO[XLEN-1:0];
            end else if (op_is_div(op_q)) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*XLEN-1:XLEN];
              lo <= prod_fix[XLEN-1:0];
            end
            done        <= 1'b1;
            div_by_zero <= div_zero;
            busy        <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl against a plain-arithmetic reference model.
module tb_mdu_seq_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  mdu_seq_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .flush       (flush),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of one operation, computed with full-width arithmetic
  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el,
                           output logic ez, output int elat);
    logic [63:0] p;
    int sq, sr;
    ez   = 1'b0;
    elat = 35;
    if (o == 2'b00) begin
      p  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (o == 2'b01) begin
      p  = {32'b0, a} * {32'b0, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'b0) begin
      eh   = a;
      el   = 32'hFFFF_FFFF;
      ez   = 1'b1;
      elat = 3;
    end else if (o == 2'b11) begin
      el = a / b;
      eh = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      el = 32'h8000_0000;
      eh = 32'h0;
    end else begin
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      el = sq;
      eh = sr;
    end
  endtask

  // Issue at the current negedge; returns at the negedge of the done cycle
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic ez;
    int elat, lat, busy_bad;
    ref_model(o, a, b, eh, el, ez, elat);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    rs_val   = $urandom;
    rt_val   = $urandom;
    lat      = 1;
    busy_bad = 0;
    while (!done && lat < 60) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " busy_during"}, 64'(busy_bad), 64'd0);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    chk({tag, " dbz"}, 64'(div_by_zero), 64'(ez));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    int          seen_done;

    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult -3x7", 2'b00, 32'hFFFF_FFFD, 32'h7);
    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'h2);
    run_op("divu 100/7", 2'b11, 32'd100, 32'd7);
    run_op("divu 5/0", 2'b11, 32'd5, 32'd0);
    run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div -9/0", 2'b10, 32'hFFFF_FFF7, 32'd0);

    for (int i = 0; i < 25; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    // mthi/mtlo preload
    hi_we = 1'b1; wdata = 32'h1111;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi", 64'(hi), 64'h1111);
    chk("mtlo", 64'(lo), 64'h2222);

    // mult 6x7 flushed at cycle 10, with an mthi attempt while busy
    start = 1'b1; op = 2'b00; rs_val = 32'd6; rt_val = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin hi_we = 1'b1; wdata = 32'hDEAD; end
      if (c == 6) hi_we = 1'b0;
      @(negedge clk);
    end
    chk("mthi while busy", 64'(hi), 64'h1111);
    chk("busy before flush", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy after flush", 64'(busy), 64'd0);
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || div_by_zero) seen_done++;
      @(negedge clk);
    end
    chk("flush no done", 64'(seen_done), 64'd0);
    chk("flush hi kept", 64'(hi), 64'h1111);
    chk("flush lo kept", 64'(lo), 64'h2222);

    // start together with flush in IDLE is dropped
    start = 1'b1; flush = 1'b1; op = 2'b11; rs_val = 32'd9; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle flush drops start", 64'(busy), 64'd0);

    // reset in the middle of a divide
    start = 1'b1; op = 2'b10; rs_val = 32'd1000; rt_val = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // back-to-back: second start issued in the first one's done cycle
    run_op("b2b first", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("b2b second", 2'b10, 32'hFFFF_FF00, 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
